hazard_scoreboard: RTL and testbench

- Producer side of the operand-forwarding path in the 5-stage RISC-V pipeline.
- Holds a shadow copy of the destination register address and write/load flags for the ID/EX, EX/MEM and MEM/WB stages. It drives the EX/MEM and MEM/WB rd/RegWrite signals consumed by operand forwarding.
- Detects load-use hazards and asserts stall and bubble controls.
- Freezes its shadow pipeline during data-memory wait states, counts stall events and flags memory-wait timeouts.

---
 rtl/hazard_scoreboard_pkg.sv | 40 ++++
 rtl/hazard_scoreboard_stall_timeout_counter.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the load-use hazard scoreboard:
// stage records, FSM encoding and the rd-0 sanitising helper.
package hazard_scoreboard_pkg;

  localparam logic [4:0] NOP_RD = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // ID/EX record: destination, RegWrite, MemRead
  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } stage_t;

  // EX/MEM and MEM/WB only need destination and RegWrite
  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
  } wb_t;

  localparam stage_t NOP_STAGE = '{rd: NOP_RD, rw: 1'b0, mr: 1'b0};
  localparam wb_t    NOP_WB    = '{rd: NOP_RD, rw: 1'b0};

  // x0 is never a real write target, so its RegWrite is dropped on capture.
  function automatic stage_t sanitize_stage(input logic [4:0] rd,
                                            input logic       rw,
                                            input logic       mr);
    stage_t s;
    s.rd = rd;
    s.rw = rw & (rd != NOP_RD);
    s.mr = mr;
    return s;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_stall_timeout_counter.sv
// Consecutive memory-wait cycle counter with a sticky timeout flag.
// Counter saturates at MEM_TIMEOUT; the flag stays set until reset.
module stall_timeout_counter #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic count_i,
  output logic timeout_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (count_i) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + TO_W'(1);
    end
    if (cnt_d == LIMIT) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow rd/RegWrite pipeline for forwarding, load-use stall/bubble
// generation, memory-wait freeze, stall event counter and wait timeout.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RS1addr_i,
  input  logic [4:0]       ID_RS2addr_i,
  input  logic             ID_uses_rs2_i,
  input  logic [4:0]       ID_RDaddr_i,
  input  logic             ID_RegWrite_i,
  input  logic             ID_MemRead_i,
  input  logic             ID_valid_i,
  input  logic             flush_i,
  input  logic             mem_stall_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             freeze_o,
  output logic [4:0]       EX_MEM_RDaddr_o,
  output logic             EX_MEM_RegWrite_o,
  output logic [4:0]       MEM_WB_RDaddr_o,
  output logic             MEM_WB_RegWrite_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic             timeout_o
);

  stage_t          id_ex_q, id_ex_d;
  wb_t             ex_mem_q, ex_mem_d;
  wb_t             mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  state_e          state_q, state_d;
  logic            lu;
  logic            wait_count;

  always_comb begin
    lu = id_ex_q.mr && (id_ex_q.rd != NOP_RD) && ID_valid_i && !flush_i &&
         ((id_ex_q.rd == ID_RS1addr_i) ||
          (ID_uses_rs2_i && (id_ex_q.rd == ID_RS2addr_i)));
  end

  assign stall_o  = lu | mem_stall_i;
  assign bubble_o = (lu | flush_i) & ~mem_stall_i;
  assign freeze_o = mem_stall_i;

  always_comb begin
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    lu_cnt_d = lu_cnt_q;
    if (!mem_stall_i) begin
      if (bubble_o || !ID_valid_i) begin
        id_ex_d = NOP_STAGE;
      end else begin
        id_ex_d = sanitize_stage(ID_RDaddr_i, ID_RegWrite_i, ID_MemRead_i);
      end
      ex_mem_d = '{rd: id_ex_q.rd, rw: id_ex_q.rw};
      mem_wb_d = ex_mem_q;
      if (lu && (lu_cnt_q != '1)) begin
        lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = mem_stall_i ? ST_WAIT : ST_RUN;
      ST_WAIT: state_d = mem_stall_i ? ST_WAIT : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_ex_q  <= NOP_STAGE;
      ex_mem_q <= NOP_WB;
      mem_wb_q <= NOP_WB;
      lu_cnt_q <= '0;
      state_q  <= ST_IDLE;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      lu_cnt_q <= lu_cnt_d;
      state_q  <= state_d;
    end
  end

  // The stalled edge that moves RUN->WAIT is counted too, so the flag
  // lands on the MEM_TIMEOUT-th consecutive stalled edge.
  assign wait_count = mem_stall_i && (state_q != ST_IDLE);

  stall_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .count_i  (wait_count),
    .timeout_o(timeout_o)
  );

  assign EX_MEM_RDaddr_o   = ex_mem_q.rd;
  assign EX_MEM_RegWrite_o = ex_mem_q.rw;
  assign MEM_WB_RDaddr_o   = mem_wb_q.rd;
  assign MEM_WB_RegWrite_o = mem_wb_q.rw;
  assign load_use_cnt_o    = lu_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  ID_RS1addr_i, ID_RS2addr_i, ID_RDaddr_i;
  logic        ID_uses_rs2_i, ID_RegWrite_i, ID_MemRead_i, ID_valid_i;
  logic        flush_i, mem_stall_i;
  logic        stall_o, bubble_o, freeze_o;
  logic [4:0]  EX_MEM_RDaddr_o, MEM_WB_RDaddr_o;
  logic        EX_MEM_RegWrite_o, MEM_WB_RegWrite_o;
  logic [15:0] load_use_cnt_o;
  logic        timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  hazard_scoreboard dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ID_RS1addr_i     (ID_RS1addr_i),
    .ID_RS2addr_i     (ID_RS2addr_i),
    .ID_uses_rs2_i    (ID_uses_rs2_i),
    .ID_RDaddr_i      (ID_RDaddr_i),
    .ID_RegWrite_i    (ID_RegWrite_i),
    .ID_MemRead_i     (ID_MemRead_i),
    .ID_valid_i       (ID_valid_i),
    .flush_i          (flush_i),
    .mem_stall_i      (mem_stall_i),
    .stall_o          (stall_o),
    .bubble_o         (bubble_o),
    .freeze_o         (freeze_o),
    .EX_MEM_RDaddr_o  (EX_MEM_RDaddr_o),
    .EX_MEM_RegWrite_o(EX_MEM_RegWrite_o),
    .MEM_WB_RDaddr_o  (MEM_WB_RDaddr_o),
    .MEM_WB_RegWrite_o(MEM_WB_RegWrite_o),
    .load_use_cnt_o   (load_use_cnt_o),
    .timeout_o        (timeout_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // advance one edge; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic v);
    ID_RS1addr_i  = rs1;
    ID_RS2addr_i  = rs2;
    ID_uses_rs2_i = u2;
    ID_RDaddr_i   = rd;
    ID_RegWrite_i = rw;
    ID_MemRead_i  = mr;
    ID_valid_i    = v;
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    mem_stall_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    $display("txn reset");
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_bubble", bubble_o, 0);
    check_eq("rst_freeze", freeze_o, 0);
    check_eq("rst_exmem_rd", EX_MEM_RDaddr_o, 0);
    check_eq("rst_cnt", load_use_cnt_o, 0);
    check_eq("rst_timeout", timeout_o, 0);
    tick();  // IDLE -> RUN

    // load x5 followed by add x6,x5,x1
    $display("txn load-use rs1");
    set_id(1, 0, 0, 5, 1, 1, 1);
    tick();
    set_id(5, 1, 1, 6, 1, 0, 1);
    check_eq("lu_stall", stall_o, 1);
    check_eq("lu_bubble", bubble_o, 1);
    tick();
    check_eq("lu_stall_drop", stall_o, 0);
    check_eq("lu_cnt1", load_use_cnt_o, 1);
    check_eq("lu_exmem_rd", EX_MEM_RDaddr_o, 5);
    check_eq("lu_exmem_rw", EX_MEM_RegWrite_o, 1);
    tick();
    check_eq("lu_memwb_rd", MEM_WB_RDaddr_o, 5);
    check_eq("lu_exmem_bubble", EX_MEM_RDaddr_o, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("add_exmem_rd", EX_MEM_RDaddr_o, 6);

    // rs2-only dependency
    $display("txn rs2 dependency");
    set_id(0, 0, 0, 5, 1, 1, 1);
    tick();
    set_id(2, 5, 1, 0, 0, 0, 1);
    check_eq("rs2_stall", stall_o, 1);
    set_id(2, 5, 0, 0, 0, 0, 1);
    check_eq("rs2_unused_nostall", stall_o, 0);
    tick();
    check_eq("rs2_cnt", load_use_cnt_o, 1);

    // load to x0
    $display("txn load x0");
    set_id(0, 0, 0, 0, 1, 1, 1);
    tick();
    set_id(0, 0, 0, 7, 1, 0, 1);
    check_eq("x0_stall", stall_o, 0);
    tick();
    check_eq("x0_exmem_rd", EX_MEM_RDaddr_o, 0);
    check_eq("x0_exmem_rw", EX_MEM_RegWrite_o, 0);

    // flush over a hazard
    $display("txn flush");
    set_id(0, 0, 0, 5, 1, 1, 1);
    tick();
    set_id(5, 0, 0, 6, 1, 0, 1);
    flush_i = 1'b1;
    #1;
    check_eq("fl_stall", stall_o, 0);
    check_eq("fl_bubble", bubble_o, 1);
    tick();
    flush_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    check_eq("fl_cnt", load_use_cnt_o, 1);
    check_eq("fl_exmem_rd", EX_MEM_RDaddr_o, 5);

    // freeze during load-use
    $display("txn freeze");
    set_id(0, 0, 0, 5, 1, 1, 1);
    tick();
    set_id(5, 0, 0, 6, 1, 0, 1);
    mem_stall_i = 1'b1;
    #1;
    check_eq("fz_stall", stall_o, 1);
    check_eq("fz_bubble", bubble_o, 0);
    check_eq("fz_freeze", freeze_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("fz_exmem_hold", EX_MEM_RDaddr_o, 0);
      check_eq("fz_memwb_hold", MEM_WB_RDaddr_o, 5);
      check_eq("fz_cnt_hold", load_use_cnt_o, 1);
    end
    mem_stall_i = 1'b0;
    #1;
    check_eq("fz_rel_bubble", bubble_o, 1);
    tick();
    check_eq("fz_rel_cnt", load_use_cnt_o, 2);
    check_eq("fz_rel_exmem", EX_MEM_RDaddr_o, 5);
    check_eq("fz_rel_stall", stall_o, 0);

    // memory-wait timeout then reset
    $display("txn timeout");
    set_id(0, 0, 0, 0, 0, 0, 0);
    mem_stall_i = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) check_eq("to_edge63", timeout_o, 0);
      if (i == 64) check_eq("to_edge64", timeout_o, 1);
    end
    mem_stall_i = 1'b0;
    tick();
    check_eq("to_sticky", timeout_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    $display("txn final reset");
    check_eq("rst2_timeout", timeout_o, 0);
    check_eq("rst2_cnt", load_use_cnt_o, 0);
    check_eq("rst2_exmem_rd", EX_MEM_RDaddr_o, 0);
    check_eq("rst2_exmem_rw", EX_MEM_RegWrite_o, 0);
    check_eq("rst2_memwb_rd", MEM_WB_RDaddr_o, 0);
    check_eq("rst2_memwb_rw", MEM_WB_RegWrite_o, 0);
    check_eq("rst2_stall", stall_o, 0);
    check_eq("rst2_freeze", freeze_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
